// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sched
// Purpose  : HI/LO owner and fixed-latency busy sequencer for E-stage mul/div
// Revision : 1.0
// ============================================================================
module muldiv_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [3:0]  Op,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic        D_hilo,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        md_stall,
  output logic        md_err
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          w_is_start_op, w_is_mult, w_is_mtx, w_busy;
  logic [63:0]   w_mul_a, w_mul_b, w_product;
  logic [31:0]   w_div_a, w_div_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic          w_sdiv;

  assign w_is_start_op = (Op >= C_OP_MULT) && (Op <= C_OP_DIVU);
  assign w_is_mult     = (Op == C_OP_MULT) || (Op == C_OP_MULTU);
  assign w_is_mtx      = (Op == C_OP_MTHI) || (Op == C_OP_MTLO);
  assign w_busy        = (cnt_q != '0);

  // One 64-bit multiplier: sign-extending for mult makes the low 64 bits the signed product.
  always_comb begin
    w_mul_a   = {{32{(Op == C_OP_MULT) & E_RD1[31]}}, E_RD1};
    w_mul_b   = {{32{(Op == C_OP_MULT) & E_RD2[31]}}, E_RD2};
    w_product = w_mul_a * w_mul_b;
  end

  // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  always_comb begin
    w_sdiv  = (Op == C_OP_DIV);
    w_div_a = (w_sdiv && E_RD1[31]) ? (~E_RD1 + 32'd1) : E_RD1;
    w_div_b = (w_sdiv && E_RD2[31]) ? (~E_RD2 + 32'd1) : E_RD2;
    w_quo   = '0;
    w_rem   = '0;
    if (w_div_b != 32'd0) begin
      w_quo = w_div_a / w_div_b;
      w_rem = w_div_a % w_div_b;
    end
    if (w_sdiv && (E_RD1[31] ^ E_RD2[31])) w_quo = ~w_quo + 32'd1;
    if (w_sdiv && E_RD1[31])               w_rem = ~w_rem + 32'd1;
  end

  always_comb begin
    if (w_is_mult) begin
      w_res_hi = w_product[63:32];
      w_res_lo = w_product[31:0];
    end else if (E_RD2 == 32'd0) begin
      w_res_hi = hi_q;
      w_res_lo = lo_q;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (w_busy) begin
      if (E_Start || w_is_mtx) err_d = 1'b1;
      if (cnt_q == C_CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
      cnt_d = cnt_q - C_CNT_ONE;
    end else begin
      if (E_Start && w_is_start_op) begin
        pend_hi_d = w_res_hi;
        pend_lo_d = w_res_lo;
        cnt_d     = w_is_mult ? C_MULT_CNT : C_DIV_CNT;
      end else if (E_Start) begin
        err_d = 1'b1;
      end
      if (Op == C_OP_MTHI) hi_d = E_RD1;
      if (Op == C_OP_MTLO) lo_d = E_RD1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Busy     = w_busy;
  assign md_err   = err_q;
  assign md_stall = D_hilo & (w_busy | (E_Start & w_is_start_op));

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// Directed self-checking bench for muldiv_sched (default 5/10-cycle latencies).
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Start;
  logic [3:0]  Op;
  logic [31:0] E_RD1, E_RD2;
  logic        D_hilo;
  logic [31:0] HI, LO;
  logic        Busy, md_stall, md_err;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_Start(E_Start), .Op(Op),
    .E_RD1(E_RD1), .E_RD2(E_RD2), .D_hilo(D_hilo),
    .HI(HI), .LO(LO), .Busy(Busy), .md_stall(md_stall), .md_err(md_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    E_Start = 1'b1; Op = op; E_RD1 = a; E_RD2 = b;
    tick();
    E_Start = 1'b0; Op = 4'd0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (Busy && cycles < 50) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; E_Start = 1'b0; Op = 4'd0; E_RD1 = '0; E_RD2 = '0; D_hilo = 1'b0;
    #2;
    n_cmp++; if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h exp 0", {HI, LO}); end
    n_cmp++; if ({Busy, md_err} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err got %b exp 00", {Busy, md_err}); end
    D_hilo = 1'b1; E_Start = 1'b1; Op = 4'd1; #1;
    n_cmp++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_issue got %b exp 1", md_stall); end
    E_Start = 1'b0; #1;
    n_cmp++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got %b exp 0", md_stall); end
    D_hilo = 1'b0; Op = 4'd0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int c;
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    n_cmp++; if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL mult_hilo_early got %h exp 0", {HI, LO}); end
    wait_idle(c);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d exp 5", c); end
    n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mult_result got %h exp FFFFFFFFFFFFFFFE", {HI, LO}); end
  endtask

  task automatic test_multu();
    int c;
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL multu_busy_cycles got %0d exp 5", c); end
    n_cmp++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_result got %h exp 00000001FFFFFFFE", {HI, LO}); end
  endtask

  task automatic test_div();
    int c;
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d exp 10", c); end
    n_cmp++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_result got %h exp FFFFFFFFFFFFFFFD", {HI, LO}); end
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(c);
    n_cmp++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow got %h exp 0000000080000000", {HI, LO}); end
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(c);
    n_cmp++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg_divisor got %h exp 00000001FFFFFFFD", {HI, LO}); end
  endtask

  task automatic test_divu();
    int c;
    issue(4'd4, 32'd7, 32'd2);
    wait_idle(c);
    n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL divu_busy_cycles got %0d exp 10", c); end
    n_cmp++; if ({HI, LO} !== 64'h0000_0001_0000_0003) begin n_fail++; $display("FAIL divu_result got %h exp 0000000100000003", {HI, LO}); end
  endtask

  task automatic test_mtx_div0();
    int c;
    Op = 4'd5; E_RD1 = 32'h1234; tick();
    n_cmp++; if (HI !== 32'h1234) begin n_fail++; $display("FAIL mthi got %h exp 00001234", HI); end
    Op = 4'd6; E_RD1 = 32'h5678; tick();
    Op = 4'd0;
    n_cmp++; if ({HI, LO} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL mtlo got %h exp 0000123400005678", {HI, LO}); end
    issue(4'd4, 32'd99, 32'd0);
    wait_idle(c);
    n_cmp++; if (c !== 10) begin n_fail++; $display("FAIL div0_busy_cycles got %0d exp 10", c); end
    n_cmp++; if ({HI, LO} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL div0_result got %h exp 0000123400005678", {HI, LO}); end
  endtask

  task automatic test_back_to_back();
    int c;
    issue(4'd2, 32'd3, 32'd5);
    wait_idle(c);
    n_cmp++; if ({HI, LO} !== 64'd15) begin n_fail++; $display("FAIL b2b_first got %h exp 15", {HI, LO}); end
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b exp 1", Busy); end
    wait_idle(c);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d exp 5", c); end
    n_cmp++; if ({HI, LO} !== 64'd1) begin n_fail++; $display("FAIL b2b_second got %h exp 1", {HI, LO}); end
    n_cmp++; if (md_err !== 1'b0) begin n_fail++; $display("FAIL b2b_no_err got %b exp 0", md_err); end
  endtask

  task automatic test_stall();
    D_hilo = 1'b1; E_Start = 1'b1; Op = 4'd3; E_RD1 = 32'd100; E_RD2 = 32'd7;
    #1;
    n_cmp++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL stall_issue got %b exp 1", md_stall); end
    tick();
    E_Start = 1'b0; Op = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      n_cmp++; if ({Busy, md_stall} !== 2'b11) begin n_fail++; $display("FAIL stall_busy_cycle_%0d got %b exp 11", k, {Busy, md_stall}); end
      tick();
    end
    n_cmp++; if ({Busy, md_stall} !== 2'b00) begin n_fail++; $display("FAIL stall_release got %b exp 00", {Busy, md_stall}); end
    n_cmp++; if ({HI, LO} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL stall_div_result got %h exp 000000020000000E", {HI, LO}); end
    D_hilo = 1'b0;
  endtask

  task automatic test_bad_start();
    issue(4'd7, 32'hDEAD_BEEF, 32'd1);
    n_cmp++; if (md_err !== 1'b1) begin n_fail++; $display("FAIL bad_start_err got %b exp 1", md_err); end
    n_cmp++; if ({Busy, HI, LO} !== {1'b0, 32'd2, 32'd14}) begin n_fail++; $display("FAIL bad_start_state got %h exp 0000000020000000E", {Busy, HI, LO}); end
    reset = 1'b0; #1;
    n_cmp++; if (md_err !== 1'b0) begin n_fail++; $display("FAIL bad_start_clear got %b exp 0", md_err); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_err_reset();
    Op = 4'd5; E_RD1 = 32'hAAAA_0000; tick();
    Op = 4'd0;
    issue(4'd3, 32'd100, 32'd7);
    tick();
    tick();
    n_cmp++; if ({Busy, md_err} !== 2'b10) begin n_fail++; $display("FAIL err_pre got %b exp 10", {Busy, md_err}); end
    E_Start = 1'b1; Op = 4'd1; E_RD1 = 32'd3; E_RD2 = 32'd3;
    tick();
    E_Start = 1'b0; Op = 4'd0;
    n_cmp++; if ({Busy, md_err} !== 2'b11) begin n_fail++; $display("FAIL err_busy_start got %b exp 11", {Busy, md_err}); end
    n_cmp++; if (HI !== 32'hAAAA_0000) begin n_fail++; $display("FAIL err_hi_held got %h exp AAAA0000", HI); end
    reset = 1'b0; #1;
    n_cmp++; if ({Busy, md_err, HI, LO} !== 66'd0) begin n_fail++; $display("FAIL err_async_reset got %h exp 0", {Busy, md_err, HI, LO}); end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    n_cmp++; if ({Busy, HI, LO} !== 65'd0) begin n_fail++; $display("FAIL err_abort_discard got %h exp 0", {Busy, HI, LO}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_mtx_div0();
    test_back_to_back();
    test_stall();
    test_bad_start();
    test_err_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the E-stage multiply/divide resource. It owns the HI/LO architectural registers and accepts mult/multu/div/divu/mthi/mtlo issues from E. It runs a fixed-latency busy counter per operation and raises the stall request that holds any HI/LO-touching instruction in D while the unit is occupied. It sits beside the ALU in E. Its HI/LO outputs travel down the pipeline for mfhi/mflo writeback.

## Interface
- MULT_CYCLES, default 5: busy cycles for mult/multu.
- DIV_CYCLES, default 10: busy cycles for div/divu. Must be ≥1.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- E_Start  in  1  issue strobe from E for a start-type op (Op 1..4).
- Op  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..15 treated as none.
- E_RD1  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- E_RD2  in  32  forwarded rt value (divisor / multiplier).
- D_hilo  in  1  instruction in D is any of mult..mflo (Op 1..8).
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- Busy  out  1  operation in progress (counter ≠ 0).
- md_stall  out  1  stall request to the hazard unit.
- md_err  out  1  sticky protocol-error flag.

## Operation
- State: HI, LO, pend_hi, pend_lo (32 b each); cnt (4 b, or wide enough for max(MULT_CYCLES, DIV_CYCLES)); md_err.
- Reset (reset=0, async): HI=LO=pend_hi=pend_lo=0, cnt=0, md_err=0. Busy=0 and md_stall follows D_hilo & E_Start combinationally.
- Idle accept (cnt=0, E_Start=1, Op∈1..4): compute the result from E_RD1/E_RD2 into pend_hi/pend_lo.
  - cnt ← MULT_CYCLES for Op 1..2.
  - cnt ← DIV_CYCLES for Op 3..4.
  - HI/LO are not yet changed.
- Count: while cnt>0, each edge decrements cnt. On the edge where cnt=1, HI←pend_hi, LO←pend_lo, cnt←0.
- mthi/mtlo (Op 5/6, cnt=0): HI (or LO) ← E_RD1 on that edge. E_Start is not required.
- mfhi/mflo (Op 7/8): no state change. The reader takes the HI/LO outputs combinationally.
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned. {HI,LO}=product.
  - div: signed. LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0: pend_hi/pend_lo ← current HI/LO. The full DIV_CYCLES latency still runs, then HI/LO are unchanged.
- md_stall = D_hilo & (Busy | (E_Start & Op∈1..4)).
- Protocol errors: when cnt≠0, any E_Start, or Op 5/6, is ignored with no state change, and sets md_err=1 until reset.
- E_Start with Op∉1..4 is ignored and sets md_err.

## Timing
- The accept edge is T0. Busy=1 during cycles T0+1 … T0+N (N = MULT_CYCLES or DIV_CYCLES).
- New HI/LO become visible in the first cycle with Busy=0, i.e. after edge T0+N.
- A back-to-back start can be accepted on edge T0+N+1 at the earliest. In the cycle after T0+N, cnt=0, so that edge accepts.
- md_stall is combinational and is asserted in the same cycle as the E-stage issue. This keeps a dependent D instruction held from the issue cycle through the last busy cycle.
- mthi/mtlo latency is 1 edge.
- Reset asserted mid-count aborts the operation. The pending result is discarded, and HI=LO=0 immediately.
- Simultaneous events: none can coexist, because accept requires cnt=0 and completion requires cnt=1.

## Test plan
- Reset, then mult 0xFFFFFFFF×2 → Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu 0xFFFFFFFF×2 → after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- div 0xFFFFFFF9(−7)/2 → Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/2 → LO=3, HI=1.
- mthi 0x1234 then mtlo 0x5678, then divu x/0 → HI=0x1234, LO=0x5678 after 10 busy cycles.
- Start div, hold D_hilo=1 → md_stall=1 in the issue cycle and all 10 busy cycles, then 0.
  - Issue mult on busy cycle 3 → ignored, md_err=1.
  - Drop reset on busy cycle 4 → Busy=0, HI=LO=0, md_err=0 immediately.
